// File: rtl/csr_timer_pkg.sv
// Shared CSR definitions for the timer/counter block: CSR numbers, TCFG/TICLR
// field positions and the ESTAT.IS bit the timer interrupt lands on.
package csr_timer_pkg;

  localparam logic [13:0] CSR_TID   = 14'h0040;
  localparam logic [13:0] CSR_TCFG  = 14'h0041;
  localparam logic [13:0] CSR_TVAL  = 14'h0042;
  localparam logic [13:0] CSR_TICLR = 14'h0044;

  localparam int TCFG_EN_BIT       = 0;
  localparam int TCFG_PERIODIC_BIT = 1;
  localparam int TCFG_INITVAL_LSB  = 2;
  localparam int TICLR_CLR_BIT     = 0;
  localparam int ESTAT_IS_TIMER    = 11;

  // Masked CSR write: bits selected by wmask take wvalue, the rest keep old_val.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_val);
  endfunction

endpackage

// File: rtl/csr_stable_cnt.sv
// Free-running 64-bit stable counter behind rdcntvl.w / rdcntvh.w.
// Counts every cycle from reset and wraps silently at 2^64.
module csr_stable_cnt (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_lo = cnt_q[31:0];
  assign cnt_hi = cnt_q[63:32];

endmodule

// File: rtl/csr_timer.sv
// Constant timer (TID/TCFG/TVAL/TICLR) plus stable counter, sharing the CSR
// file's write port; timer_int is the level source for ESTAT.IS[11].
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        csr_hit,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [31:0] tid,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  localparam logic [TIMER_W-1:0] CNT_ONES = '1;
  localparam logic [TIMER_W-1:0] CNT_ONE  = TIMER_W'(1);

  logic               tcfg_en;
  logic               tcfg_periodic;
  logic [TIMER_W-3:0] tcfg_initval;
  logic [TIMER_W-1:0] timer_cnt;
  logic [TIMER_W-1:0] timer_cnt_nxt;
  logic               timer_fire;

  logic sel_tid;
  logic sel_tcfg;
  logic sel_tval;
  logic sel_ticlr;
  logic tid_wr;
  logic tcfg_wr;
  logic ticlr_clr;

  logic [31:0]        tcfg_rd;
  logic [31:0]        tcfg_new;
  logic [31:0]        tval_rd;
  logic [TIMER_W-3:0] new_initval;

  assign sel_tid   = (csr_num == CSR_TID);
  assign sel_tcfg  = (csr_num == CSR_TCFG);
  assign sel_tval  = (csr_num == CSR_TVAL);
  assign sel_ticlr = (csr_num == CSR_TICLR);

  assign tid_wr    = csr_we & sel_tid;
  assign tcfg_wr   = csr_we & sel_tcfg;
  assign ticlr_clr = csr_we & sel_ticlr
                   & csr_wmask[TICLR_CLR_BIT] & csr_wvalue[TICLR_CLR_BIT];

  // TCFG as software sees it; bits at and above TIMER_W read as zero.
  always_comb begin
    tcfg_rd                                   = '0;
    tcfg_rd[TCFG_EN_BIT]                      = tcfg_en;
    tcfg_rd[TCFG_PERIODIC_BIT]                = tcfg_periodic;
    tcfg_rd[TIMER_W-1:TCFG_INITVAL_LSB]       = tcfg_initval;
  end

  always_comb begin
    tval_rd                = '0;
    tval_rd[TIMER_W-1:0]   = timer_cnt;
  end

  assign tcfg_new    = csr_merge(tcfg_rd, csr_wmask, csr_wvalue);
  assign new_initval = tcfg_new[TIMER_W-1:TCFG_INITVAL_LSB];

  // All-ones is the halted state: a one-shot timer parks there after firing.
  always_comb begin
    timer_cnt_nxt = timer_cnt;
    timer_fire    = 1'b0;
    if (tcfg_wr) begin
      timer_cnt_nxt = {new_initval, 2'b00};
    end else if (tcfg_en && (timer_cnt != CNT_ONES)) begin
      if (timer_cnt == '0) begin
        timer_fire    = 1'b1;
        timer_cnt_nxt = tcfg_periodic ? {tcfg_initval, 2'b00} : CNT_ONES;
      end else begin
        timer_cnt_nxt = timer_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_initval  <= '0;
      timer_cnt     <= CNT_ONES;
      timer_int     <= 1'b0;
      tid           <= CORE_ID;
    end else begin
      if (tcfg_wr) begin
        tcfg_en       <= tcfg_new[TCFG_EN_BIT];
        tcfg_periodic <= tcfg_new[TCFG_PERIODIC_BIT];
        tcfg_initval  <= new_initval;
      end
      timer_cnt <= timer_cnt_nxt;
      // A fresh expiry wins over a clear landing in the same cycle.
      if (timer_fire) begin
        timer_int <= 1'b1;
      end else if (ticlr_clr) begin
        timer_int <= 1'b0;
      end
      if (tid_wr) begin
        tid <= csr_merge(tid, csr_wmask, csr_wvalue);
      end
    end
  end

  assign csr_hit = sel_tid | sel_tcfg | sel_tval | sel_ticlr;

  // Non-hit numbers return zero so the CSR file can OR this into its own read.
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_TID:  csr_rvalue = tid;
      CSR_TCFG: csr_rvalue = tcfg_rd;
      CSR_TVAL: csr_rvalue = tval_rd;
      default:  csr_rvalue = '0;
    endcase
  end

  csr_stable_cnt u_stable_cnt (
    .clk    (clk),
    .reset  (reset),
    .cnt_lo (cnt_lo),
    .cnt_hi (cnt_hi)
  );

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: a directed vector table, hand-written
// timer sequences and a randomized run against a behavioural model.
module tb_csr_timer;
  import csr_timer_pkg::*;

  localparam logic [31:0] CORE_ID_TB = 32'h0000_0003;
  localparam logic [31:0] ONES       = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_we = 1'b0;
  logic [13:0] csr_num = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic        csr_hit;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [31:0] tid;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: TCFG image, timer value, interrupt, TID, stable count.
  logic [31:0] m_cfg;
  logic [31:0] m_cnt;
  logic        m_int;
  logic [31:0] m_tid;
  logic [63:0] m_stable;

  logic [31:0] last_rd;
  logic        last_hit;

  typedef struct {
    logic        we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wvalue;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;

  vec_t vecs[13];

  csr_timer #(
    .TIMER_W (32),
    .CORE_ID (CORE_ID_TB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .csr_hit    (csr_hit),
    .csr_rvalue (csr_rvalue),
    .timer_int  (timer_int),
    .tid        (tid),
    .cnt_lo     (cnt_lo),
    .cnt_hi     (cnt_hi)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [13:0] num);
    return (num == CSR_TID) || (num == CSR_TCFG) || (num == CSR_TVAL) || (num == CSR_TICLR);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] num);
    if (num == CSR_TID)  return m_tid;
    if (num == CSR_TCFG) return m_cfg;
    if (num == CSR_TVAL) return m_cnt;
    return 32'h0;
  endfunction

  // One clock of the architectural rules, applied to the model.
  task automatic model_update(input logic rst, input logic we, input logic [13:0] num,
                              input logic [31:0] mask, input logic [31:0] value);
    logic fire;
    if (rst) begin
      m_cfg    = 32'h0;
      m_cnt    = ONES;
      m_int    = 1'b0;
      m_tid    = CORE_ID_TB;
      m_stable = 64'd0;
      return;
    end
    fire     = 1'b0;
    m_stable = m_stable + 64'd1;
    if (we && num == CSR_TCFG) begin
      m_cfg = (m_cfg & ~mask) | (value & mask);
      m_cnt = m_cfg & ~32'd3;
    end else if (m_cfg[0] && m_cnt != ONES) begin
      if (m_cnt == 32'd0) begin
        fire  = 1'b1;
        m_cnt = m_cfg[1] ? (m_cfg & ~32'd3) : ONES;
      end else begin
        m_cnt = m_cnt - 32'd1;
      end
    end
    if (fire) m_int = 1'b1;
    else if (we && num == CSR_TICLR && mask[0] && value[0]) m_int = 1'b0;
    if (we && num == CSR_TID) m_tid = (m_tid & ~mask) | (value & mask);
  endtask

  task automatic check_state();
    check("timer_int", {31'b0, timer_int}, {31'b0, m_int});
    check("tid", tid, m_tid);
    check("cnt_lo", cnt_lo, m_stable[31:0]);
    check("cnt_hi", cnt_hi, m_stable[63:32]);
  endtask

  // Driver: called at a falling edge; checks the combinational read, clocks once,
  // then checks registered state at the next falling edge.
  task automatic step(input logic we, input logic [13:0] num,
                      input logic [31:0] mask, input logic [31:0] value);
    csr_we     = we;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = value;
    #1;
    last_rd  = csr_rvalue;
    last_hit = csr_hit;
    check("csr_hit", {31'b0, csr_hit}, {31'b0, m_hit(num)});
    check("csr_rvalue", csr_rvalue, m_read(num));
    @(posedge clk);
    model_update(reset, we, num, mask, value);
    @(negedge clk);
    csr_we = 1'b0;
    check_state();
  endtask

  task automatic rd_tval();
    step(1'b0, CSR_TVAL, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] value);
    step(1'b1, num, ONES, value);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, CSR_TVAL, 32'h0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, CSR_TID,   32'h0,        32'h0,        1'b1, CORE_ID_TB,   1'b0};
    vecs[1]  = '{1'b1, CSR_TID,   32'hFFFF0000, 32'h12345678, 1'b1, CORE_ID_TB,   1'b0};
    vecs[2]  = '{1'b0, CSR_TID,   32'h0,        32'h0,        1'b1, 32'h12340003, 1'b0};
    vecs[3]  = '{1'b1, CSR_TVAL,  ONES,         32'h0,        1'b1, ONES,         1'b0};
    vecs[4]  = '{1'b0, CSR_TVAL,  32'h0,        32'h0,        1'b1, ONES,         1'b0};
    vecs[5]  = '{1'b0, CSR_TICLR, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 14'h0043,  32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 14'h0005,  ONES,         ONES,         1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, CSR_TCFG,  32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, CSR_TCFG,  32'hFFFFFFFC, 32'h00000013, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, CSR_TCFG,  32'h0,        32'h0,        1'b1, 32'h00000010, 1'b0};
    vecs[11] = '{1'b0, CSR_TVAL,  32'h0,        32'h0,        1'b1, 32'h00000010, 1'b0};
    vecs[12] = '{1'b0, CSR_TVAL,  32'h0,        32'h0,        1'b1, 32'h00000010, 1'b0};

    // Two reset edges, then release at a falling edge.
    @(negedge clk);
    @(negedge clk);
    model_update(1'b1, 1'b0, 14'h0, 32'h0, 32'h0);
    check_state();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) rd_tval();
    check("t1_cnt_lo", cnt_lo, 32'd10);
    check("t1_tval", last_rd, ONES);
    check("t1_int", {31'b0, timer_int}, 32'h0);
    check("t1_tid", tid, CORE_ID_TB);

    // Directed CSR access table.
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].num, vecs[i].mask, vecs[i].wvalue);
      check("vec_hit", {31'b0, last_hit}, {31'b0, vecs[i].exp_hit});
      check("vec_rd", last_rd, vecs[i].exp_rd);
      check("vec_int", {31'b0, timer_int}, {31'b0, vecs[i].exp_int});
    end

    // One-shot InitVal=4: counts 16..0, fires once, then parks at all-ones.
    do_reset();
    wr(CSR_TCFG, 32'h0000_0011);
    for (int k = 16; k >= 0; k--) begin
      rd_tval();
      check("t2_tval", last_rd, 32'(k));
      check("t2_int", {31'b0, timer_int}, {31'b0, (k == 0)});
    end
    for (int i = 0; i < 3; i++) begin
      rd_tval();
      check("t2_halt", last_rd, ONES);
      check("t2_int_hold", {31'b0, timer_int}, 32'h1);
    end

    // Periodic InitVal=2: 8..0 then reload, interrupt sticky until TICLR.
    do_reset();
    wr(CSR_TCFG, 32'h0000_000B);
    for (int k = 8; k >= 0; k--) begin
      rd_tval();
      check("t3_tval", last_rd, 32'(k));
      check("t3_int", {31'b0, timer_int}, {31'b0, (k == 0)});
    end
    for (int k = 8; k >= 6; k--) begin
      rd_tval();
      check("t3_reload", last_rd, 32'(k));
      check("t3_int_sticky", {31'b0, timer_int}, 32'h1);
    end
    wr(CSR_TICLR, 32'h1);
    check("t3_ticlr_rd", last_rd, 32'h0);
    check("t3_cleared", {31'b0, timer_int}, 32'h0);

    // Clear on the same cycle the counter expires: the set wins.
    for (int k = 4; k >= 1; k--) begin
      rd_tval();
      check("t4_tval", last_rd, 32'(k));
    end
    wr(CSR_TICLR, 32'h1);
    check("t4_set_wins", {31'b0, timer_int}, 32'h1);
    rd_tval();
    check("t4_reload", last_rd, 32'd8);

    // Mid-count TCFG rewrite, then disable freezes the reloaded value.
    do_reset();
    wr(CSR_TCFG, 32'h0000_0011);
    for (int k = 16; k >= 6; k--) rd_tval();
    check("t5_before", last_rd, 32'd6);
    wr(CSR_TCFG, 32'h0000_0005);
    rd_tval();
    check("t5_load", last_rd, 32'd4);
    rd_tval();
    check("t5_dec", last_rd, 32'd3);
    step(1'b1, CSR_TCFG, 32'h1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd_tval();
      check("t5_frozen", last_rd, 32'd4);
    end

    // Periodic InitVal=0 fires every cycle, even against a steady TICLR.
    do_reset();
    wr(CSR_TCFG, 32'h0000_0003);
    for (int i = 0; i < 4; i++) begin
      wr(CSR_TICLR, 32'h1);
      check("t0_int", {31'b0, timer_int}, 32'h1);
    end
    rd_tval();
    check("t0_tval", last_rd, 32'h0);

    // Stable counter carry from low to high word.
    force dut.u_stable_cnt.cnt_q = 64'h0000_0005_FFFF_FFFF;
    #1;
    release dut.u_stable_cnt.cnt_q;
    m_stable = 64'h0000_0005_FFFF_FFFF;
    #1;
    check("t6_preset", cnt_lo, ONES);
    rd_tval();
    check("t6_lo_wrap", cnt_lo, 32'h0);
    check("t6_hi_carry", cnt_hi, 32'h6);

    // Reset mid-count, with a TCFG write on the same cycle.
    wr(CSR_TCFG, 32'h0000_0011);
    for (int i = 0; i < 3; i++) rd_tval();
    wr(CSR_TID, 32'hDEAD_BEEF);
    reset = 1'b1;
    step(1'b1, CSR_TCFG, ONES, 32'h0000_0007);
    reset = 1'b0;
    check("t6_rst_int", {31'b0, timer_int}, 32'h0);
    check("t6_rst_tid", tid, CORE_ID_TB);
    check("t6_rst_lo", cnt_lo, 32'h0);
    check("t6_rst_hi", cnt_hi, 32'h0);
    rd_tval();
    check("t6_rst_tval", last_rd, ONES);
    step(1'b0, CSR_TCFG, 32'h0, 32'h0);
    check("t6_rst_tcfg", last_rd, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      logic        we;
      logic [13:0] num;
      logic [31:0] mask;
      logic [31:0] value;
      sel   = $urandom_range(0, 9);
      we    = ($urandom_range(0, 3) != 0);
      mask  = ($urandom_range(0, 3) == 0) ? $urandom : ONES;
      value = $urandom;
      case (sel)
        0, 1, 2: begin
          num   = CSR_TCFG;
          value = (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) value = value | ($urandom & 32'hFFFF_FF00);
        end
        3:       num = CSR_TID;
        4:       num = CSR_TICLR;
        5:       num = CSR_TVAL;
        6:       num = 14'($urandom_range(0, 16383));
        default: begin
          num = CSR_TVAL;
          we  = 1'b0;
        end
      endcase
      reset = ($urandom_range(0, 79) == 0);
      step(we, num, mask, value);
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
